// File: rtl/params_pkg.sv
// Shared types for the AXI4-Lite to APB bridge: AXI response codes and FSM states.
package params_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} bridge_state_t;

endpackage

// File: rtl/apb_if.sv
// APB peripheral bus bundle; the bridge drives it through the master modport.
interface apb_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;

    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pready);
endinterface

// File: rtl/axil_apb_bridge.sv
// AXI4-Lite slave to APB master bridge: one transaction at a time, round-robin
// read/write arbitration, and a wait-state timeout that reports SLVERR.
module axil_apb_bridge
    import params_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [31:0]             s_axil_awaddr,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    input  logic [31:0]             s_axil_araddr,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    output logic [DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,
    apb_if.master                   apb
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    bridge_state_t    state;
    axi_resp_t        resp;
    logic             prefer_write;
    logic [CNT_W-1:0] wait_cnt;
    logic             write_pending;
    logic             read_pending;
    logic             take_write;
    logic             take_read;
    logic             unused_bits;

    assign write_pending = s_axil_awvalid && s_axil_wvalid;
    assign read_pending  = s_axil_arvalid;

    // Readies are decoded from IDLE so acceptance lands in the same cycle the
    // request is seen; a registered version would cost a cycle per transfer.
    assign take_write = (state == IDLE) && write_pending && (!read_pending || prefer_write);
    assign take_read  = (state == IDLE) && read_pending && !(write_pending && prefer_write);

    assign s_axil_awready = take_write;
    assign s_axil_wready  = take_write;
    assign s_axil_arready = take_read;
    assign s_axil_bresp   = resp;
    assign s_axil_rresp   = resp;

    assign unused_bits = ^{s_axil_wstrb, s_axil_awaddr[31:ADDR_WIDTH], s_axil_araddr[31:ADDR_WIDTH]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            resp          <= RESP_OKAY;
            prefer_write  <= 1'b1;
            wait_cnt      <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            apb.psel      <= 1'b0;
            apb.penable   <= 1'b0;
            apb.pwrite    <= 1'b0;
            apb.paddr     <= '0;
            apb.pwdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_write) begin
                        apb.paddr    <= s_axil_awaddr[ADDR_WIDTH-1:0];
                        apb.pwdata   <= s_axil_wdata;
                        apb.pwrite   <= 1'b1;
                        apb.psel     <= 1'b1;
                        prefer_write <= 1'b0;
                        state        <= SETUP;
                    end else if (take_read) begin
                        apb.paddr    <= s_axil_araddr[ADDR_WIDTH-1:0];
                        apb.pwrite   <= 1'b0;
                        apb.psel     <= 1'b1;
                        prefer_write <= 1'b1;
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    apb.penable <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (apb.pready) begin
                        if (!apb.pwrite) s_axil_rdata <= apb.prdata;
                        resp          <= RESP_OKAY;
                        apb.psel      <= 1'b0;
                        apb.penable   <= 1'b0;
                        s_axil_bvalid <= apb.pwrite;
                        s_axil_rvalid <= !apb.pwrite;
                        state         <= RESP;
                    end else if (TIMEOUT_CYCLES != 0 && wait_cnt == CNT_MAX) begin
                        resp          <= RESP_SLVERR;
                        s_axil_rdata  <= '0;
                        apb.psel      <= 1'b0;
                        apb.penable   <= 1'b0;
                        s_axil_bvalid <= apb.pwrite;
                        s_axil_rvalid <= !apb.pwrite;
                        state         <= RESP;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if ((s_axil_bvalid && s_axil_bready) || (s_axil_rvalid && s_axil_rready)) begin
                        s_axil_bvalid <= 1'b0;
                        s_axil_rvalid <= 1'b0;
                        wait_cnt      <= '0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_apb_bridge.sv
// Directed bench for axil_apb_bridge with a behavioural APB slave and a response scoreboard.
module tb_axil_apb_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] s_axil_awaddr, s_axil_wdata, s_axil_araddr, s_axil_rdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
    logic [1:0]  s_axil_bresp, s_axil_rresp;
    logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
    logic        s_axil_rvalid, s_axil_rready;

    apb_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) apb ();

    axil_apb_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .apb(apb)
    );

    always #5 clk = ~clk;

    // Behavioural APB slave: register file, programmable wait states, optional hang.
    logic [31:0] mem [16];
    int          acc_n = 0;
    int          slv_wait = 0;
    bit          slv_stuck = 1'b0;

    assign apb.pready = !slv_stuck && (acc_n >= slv_wait);
    assign apb.prdata = mem[apb.paddr[5:2]];

    always @(posedge clk) begin
        if (apb.psel && apb.penable) begin
            if (apb.pready) begin
                acc_n <= 0;
                if (apb.pwrite) mem[apb.paddr[5:2]] <= apb.pwdata;
            end else begin
                acc_n <= acc_n + 1;
            end
        end else begin
            acc_n <= 0;
        end
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          acc_cyc;
        int          lat;
    } exp_t;

    op_t         wq[$];
    op_t         rq[$];
    exp_t        sb[$];
    logic [31:0] ref_mem [16];
    logic [7:0]  order;
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_write(input logic [31:0] a, input logic [31:0] d);
        op_t o;
        o.wr = 1'b1; o.addr = a; o.data = d;
        wq.push_back(o);
    endtask

    task automatic push_read(input logic [31:0] a);
        op_t o;
        o.wr = 1'b0; o.addr = a; o.data = '0;
        rq.push_back(o);
    endtask

    task automatic expect_accept(input bit wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.wr      = wr;
        e.addr    = a;
        e.wdata   = d;
        e.acc_cyc = cyc;
        e.lat     = slv_stuck ? TO + 3 : slv_wait + 3;
        e.resp    = slv_stuck ? 2'b10 : 2'b00;
        e.rdata   = slv_stuck ? 32'h0 : ref_mem[a[5:2]];
        if (wr && !slv_stuck) ref_mem[a[5:2]] = d;
        sb.push_back(e);
        order = {order[6:0], wr};
    endtask

    // Drives the queued operations, records acceptances into the scoreboard
    // and checks APB phases and AXI responses until everything has drained.
    task automatic run_ops(input int budget);
        bit   acc_w = 1'b0;
        bit   acc_r = 1'b0;
        int   n = 0;
        exp_t e;
        while ((wq.size() > 0 || rq.size() > 0 || sb.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
            cyc++;
            if (s_axil_bvalid || s_axil_rvalid) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", {30'b0, s_axil_bvalid, s_axil_rvalid}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("resp_latency", cyc - e.acc_cyc, e.lat);
                    check("resp_kind_bvalid", s_axil_bvalid, e.wr);
                    check("resp_kind_rvalid", s_axil_rvalid, !e.wr);
                    check("resp_code", e.wr ? s_axil_bresp : s_axil_rresp, e.resp);
                    if (!e.wr) check("rdata", s_axil_rdata, e.rdata);
                    check("psel_in_resp", apb.psel, 1'b0);
                end
            end else if (sb.size() > 0) begin
                if (cyc - sb[0].acc_cyc == 1) begin
                    check("setup_psel", apb.psel, 1'b1);
                    check("setup_penable", apb.penable, 1'b0);
                end else begin
                    check("access_psel", apb.psel, 1'b1);
                    check("access_penable", apb.penable, 1'b1);
                end
                check("paddr", apb.paddr, sb[0].addr[15:0]);
                check("pwrite", apb.pwrite, sb[0].wr);
                if (sb[0].wr) check("pwdata", apb.pwdata, sb[0].wdata);
            end
            if (acc_w) begin void'(wq.pop_front()); acc_w = 1'b0; end
            if (acc_r) begin void'(rq.pop_front()); acc_r = 1'b0; end
            s_axil_awvalid = wq.size() > 0;
            s_axil_wvalid  = wq.size() > 0;
            s_axil_arvalid = rq.size() > 0;
            if (wq.size() > 0) begin s_axil_awaddr = wq[0].addr; s_axil_wdata = wq[0].data; end
            if (rq.size() > 0) s_axil_araddr = rq[0].addr;
            #1;
            if (s_axil_awready && s_axil_awvalid) begin
                check("wready_with_awready", s_axil_wready, 1'b1);
                check("arready_during_write_accept", s_axil_arready, 1'b0);
                check("psel_at_accept", apb.psel, 1'b0);
                expect_accept(1'b1, wq[0].addr, wq[0].data);
                acc_w = 1'b1;
            end else if (s_axil_arready && s_axil_arvalid) begin
                check("awready_during_read_accept", s_axil_awready, 1'b0);
                check("psel_at_accept", apb.psel, 1'b0);
                expect_accept(1'b0, rq[0].addr, 32'h0);
                acc_r = 1'b1;
            end
        end
        check("run_budget_expired", n >= budget, 1'b0);
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        s_axil_arvalid = 1'b0;
    endtask

    initial begin
        int w;
        int stray;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        reset_n        = 1'b0;
        s_axil_awaddr  = '0; s_axil_awvalid = 1'b0;
        s_axil_wdata   = '0; s_axil_wstrb   = '0; s_axil_wvalid = 1'b0;
        s_axil_araddr  = '0; s_axil_arvalid = 1'b0;
        s_axil_bready  = 1'b1; s_axil_rready = 1'b1;
        order = '0;
        repeat (3) @(negedge clk);
        check("rst_awready", s_axil_awready, 1'b0);
        check("rst_arready", s_axil_arready, 1'b0);
        check("rst_bvalid", s_axil_bvalid, 1'b0);
        check("rst_rvalid", s_axil_rvalid, 1'b0);
        check("rst_bresp", s_axil_bresp, 2'b00);
        check("rst_rresp", s_axil_rresp, 2'b00);
        check("rst_rdata", s_axil_rdata, 32'h0);
        check("rst_psel", apb.psel, 1'b0);
        check("rst_penable", apb.penable, 1'b0);
        check("rst_pwrite", apb.pwrite, 1'b0);
        check("rst_paddr", apb.paddr, 16'h0);
        check("rst_pwdata", apb.pwdata, 32'h0);
        reset_n = 1'b1;

        // Zero-wait write to the GPIO register.
        push_write(32'h0000_0000, 32'h0000_005A);
        run_ops(50);
        check("gpio_out", mem[0][7:0], 8'h5A);

        // Write then read back.
        push_write(32'h0000_0004, 32'h0000_00F0);
        run_ops(50);
        push_read(32'h0000_0004);
        run_ops(50);

        // Contention with both kinds pending continuously: expect W, R, W.
        order = '0;
        push_write(32'h0000_0008, 32'h0000_0011);
        push_write(32'h0000_000C, 32'h0000_0022);
        push_read(32'h0000_0008);
        run_ops(100);
        check("arb_order", {5'b0, order[2:0]}, 8'b0000_0101);

        // Five APB wait states.
        slv_wait = 5;
        push_write(32'h0001_0010, 32'h0000_0033);
        run_ops(60);
        push_read(32'h0000_0010);
        run_ops(60);
        slv_wait = 0;

        // Hung peripheral: read and write both abort with SLVERR.
        slv_stuck = 1'b1;
        push_read(32'h0000_0004);
        run_ops(60);
        push_write(32'h0000_0004, 32'h0000_0099);
        run_ops(60);
        slv_stuck = 1'b0;
        push_read(32'h0000_0004);
        run_ops(60);

        // Reset in the middle of ACCESS abandons the transfer.
        slv_wait = 20;
        @(negedge clk);
        s_axil_awaddr = 32'h14; s_axil_wdata = 32'h77;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        #1;
        w = 0;
        while (!s_axil_awready && w < 10) begin @(negedge clk); #1; w++; end
        check("rst_test_accept_wait", w >= 10, 1'b0);
        @(negedge clk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        @(negedge clk);
        check("rst_test_in_access", apb.penable, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_psel", apb.psel, 1'b0);
        check("async_rst_penable", apb.penable, 1'b0);
        check("async_rst_pwrite", apb.pwrite, 1'b0);
        check("async_rst_paddr", apb.paddr, 16'h0);
        check("async_rst_pwdata", apb.pwdata, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        slv_wait = 0;
        stray = 0;
        repeat (25) begin
            @(negedge clk);
            if (s_axil_bvalid || s_axil_rvalid || apb.psel) stray++;
        end
        check("no_resp_after_reset", stray, 0);

        push_read(32'h0000_0000);
        run_ops(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/axil_apb_bridge.md
# axil_apb_bridge

AXI4-Lite slave to APB master bridge. Accepts single-beat AXI4-Lite reads and writes from the interconnect and drives them as APB transfers onto the peripheral bus that the GPIO, UART and timer blocks sit on. Handles one transaction at a time, with fair read/write arbitration and a wait-state timeout that turns a hung peripheral into an AXI SLVERR.

## Interface
- ADDR_WIDTH, 16, APB `paddr` width; AXI address bits above this are ignored.
- DATA_WIDTH, 32, data width on both AXI and APB.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles with `pready` low before abort; 0 disables the timeout.

Ports (clock and reset first):
- clk  in  1  single clock for both sides.
- reset_n  in  1  asynchronous, active-low reset.
- s_axil_awaddr  in  32  write address.
- s_axil_awvalid / s_axil_awready  in / out  1  AW handshake.
- s_axil_wdata  in  DATA_WIDTH  write data.
- s_axil_wstrb  in  DATA_WIDTH/8  ignored; every write is a full word.
- s_axil_wvalid / s_axil_wready  in / out  1  W handshake.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid / s_axil_bready  out / in  1  B handshake.
- s_axil_araddr  in  32  read address.
- s_axil_arvalid / s_axil_arready  in / out  1  AR handshake.
- s_axil_rdata  out  DATA_WIDTH  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid / s_axil_rready  out / in  1  R handshake.
- apb  apb_if.master  —  drives `psel`, `penable`, `pwrite`, `paddr`, `pwdata`; samples `prdata` and `pready`.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - A write is pending when `awvalid && wvalid`. A read is pending when `arvalid`.
  - If only one kind is pending, accept it.
  - If both are pending, round-robin: the kind not served last wins. Write wins first after reset.
  - Accepting a write pulses `awready` and `wready` together for one cycle. Accepting a read pulses `arready` for one cycle.
  - On acceptance, latch `paddr` = addr[ADDR_WIDTH-1:0], `pwrite`, and `pwdata`; go to SETUP.
  - `awready`, `wready` and `arready` are never high outside the IDLE acceptance cycle.
- SETUP: `psel`=1, `penable`=0; go to ACCESS.
- ACCESS:
  - `psel`=1, `penable`=1.
  - If `pready`=1: latch `prdata` into `rdata` (reads only), set resp = OKAY, go to RESP.
  - Otherwise, increment the wait counter. When the counter reaches TIMEOUT_CYCLES (nonzero), abort: resp = SLVERR, `rdata` = 0, go to RESP.
- RESP:
  - `psel` and `penable` are 0.
  - Assert `bvalid` (write) or `rvalid` (read) and hold it, with resp and data stable, until `bready` / `rready`.
  - Then go to IDLE and clear the wait counter.
- `paddr`, `pwrite` and `pwdata` stay stable from SETUP through the end of ACCESS.
- Reset values: all AXI ready/valid = 0, `bresp`/`rresp` = 0, `rdata` = 0, `psel`/`penable`/`pwrite` = 0, `paddr`/`pwdata` = 0, state = IDLE, arbitration pointer = write-first, wait counter = 0.
- Reset asserted mid-transaction abandons it immediately. No response is issued.

## Timing
- Zero-wait transfer: acceptance in cycle T, SETUP in T+1, ACCESS in T+2, valid in T+3.
- If the master's ready is high at T+3, the next acceptance can happen at T+4.
- Each APB wait state adds exactly one cycle.
- Timeout: with the peripheral stuck, the response is valid TIMEOUT_CYCLES+3 cycles after acceptance.
- The wait counter is sized to $clog2(TIMEOUT_CYCLES+1) bits and must not wrap.

## Structure
- params_pkg gets:
  - `axi_resp_t` constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
  - `bridge_state_t` enum {IDLE, SETUP, ACCESS, RESP}.
- Single module, no sub-module. The timeout counter is small enough to live inline.

## Test plan
- Write 0x0000005A to 0x0000 against the GPIO slave (pready tied 1):
  - `psel` high at T+1, `penable` high at T+2, `pwdata` = 0x5A.
  - `bvalid` at T+3 with `bresp` = 00; `gpio_out` = 0x5A afterwards.
- Read 0x0004 after writing 0xF0 to it: `rvalid` at T+3, `rdata` = 0x000000F0, `rresp` = 00.
- AW/W and AR valid in the same cycle, twice in a row:
  - Write is served first, then the read, then the write again.
  - No overlap of `psel` between transactions.
- Slave holds `pready` low for 5 cycles: response delayed by exactly 5 cycles, OKAY, data correct.
- TIMEOUT_CYCLES=8 with `pready` stuck 0 on a read:
  - `rvalid` at T+11 with `rresp` = 10 and `rdata` = 0.
  - `psel` drops in the same cycle the abort is taken.
- `reset_n` pulsed low during ACCESS: all outputs return to reset values asynchronously, and no `bvalid`/`rvalid` is ever issued for that transfer.
